// File: rtl/piso_serializer_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
// Frame length grows by one parity bit when PISO_SERIALIZER_PARITY_EN is defined.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Ceiling log2, used to size the bit counter.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

    function automatic int flen(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready input and frame markers.
// Optional even-parity trailer bit enabled by the PISO_SERIALIZER_PARITY_EN macro.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic [WIDTH-1:0] idata,
    input  logic             ivalid,
    output logic             oready,
    output logic             oq,
    output logic             oframe,
    output logic             odone,
    output logic             obusy
);

    localparam int FLEN  = flen(WIDTH);
    localparam int CNT_W = clog2(FLEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FLEN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               q_q, q_d;
    logic               frame_q, frame_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic               par_q, par_d;
`endif

    logic               last_bit;
    logic               xfer;
    logic [CNT_W-1:0]   cnt_inc;

    // cnt_q indexes the bit currently on oq, so the last-bit cycle is also the reload cycle.
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    assign oready   = (state_q == IDLE) || last_bit;
    assign xfer     = ivalid && oready;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        q_d     = 1'b0;
        frame_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        if (xfer) begin
            state_d = SHIFT;
            cnt_d   = '0;
            frame_d = 1'b1;
            busy_d  = 1'b1;
            q_d     = MSB_FIRST ? idata[WIDTH-1] : idata[0];
            shreg_d = MSB_FIRST ? {idata[WIDTH-2:0], 1'b0} : {1'b0, idata[WIDTH-1:1]};
`ifdef PISO_SERIALIZER_PARITY_EN
            par_d   = ^idata;
`endif
        end else if (last_bit) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (state_q == SHIFT) begin
            cnt_d   = cnt_inc;
            busy_d  = 1'b1;
            done_d  = (cnt_inc == LAST_IDX);
            q_d     = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
            shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
`ifdef PISO_SERIALIZER_PARITY_EN
            if (cnt_inc == CNT_W'(WIDTH)) q_d = par_q;
`endif
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            q_q     <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            q_q     <= q_d;
            frame_q <= frame_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign oq     = q_q;
    assign oframe = frame_q;
    assign odone  = done_q;
    assign obusy  = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream.
// Expected per-cycle serial output is queued at each transfer and popped by a monitor.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    typedef struct packed {
        logic q_msb;
        logic q_lsb;
        logic frame;
        logic done;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] idata;
    logic         ivalid;
    logic         rdy_m, q_m, frm_m, dn_m, bsy_m;
    logic         rdy_l, q_l, frm_l, dn_l, bsy_l;

    exp_t         sb[$];
    logic         exp_ready;
    int           n_checks;
    int           n_fail;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .iclk(clk), .irst_n(rst_n), .idata(idata), .ivalid(ivalid),
        .oready(rdy_m), .oq(q_m), .oframe(frm_m), .odone(dn_m), .obusy(bsy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .iclk(clk), .irst_n(rst_n), .idata(idata), .ivalid(ivalid),
        .oready(rdy_l), .oq(q_l), .oframe(frm_l), .odone(dn_l), .obusy(bsy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is the word's bits in send order, then even parity if enabled.
    task automatic push_frame(input logic [W-1:0] w);
        exp_t e;
        for (int k = 0; k < FL; k++) begin
            if (k < W) begin
                e.q_msb = w[W-1-k];
                e.q_lsb = w[k];
            end else begin
                e.q_msb = logic'($countones(w) % 2);
                e.q_lsb = e.q_msb;
            end
            e.frame = (k == 0);
            e.done  = (k == FL - 1);
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic have;
        have = 1'b0;
        e    = '0;
        if (sb.size() > 0) begin
            e    = sb.pop_front();
            have = 1'b1;
        end
        exp_ready = (sb.size() == 0);
        if (rst_n) begin
            check("oq_msb",    q_m,   e.q_msb);
            check("oq_lsb",    q_l,   e.q_lsb);
            check("oframe_m",  frm_m, e.frame);
            check("oframe_l",  frm_l, e.frame);
            check("odone_m",   dn_m,  e.done);
            check("odone_l",   dn_l,  e.done);
            check("obusy_m",   bsy_m, have);
            check("obusy_l",   bsy_l, have);
            check("oready_m",  rdy_m, exp_ready);
            check("oready_l",  rdy_l, exp_ready);
        end
    end

    task automatic drive_cycle(input logic v, input logic [W-1:0] d, output logic accepted);
        @(negedge clk);
        #1;
        ivalid   = v;
        idata    = d;
        accepted = v && exp_ready && rst_n;
        if (accepted) push_frame(d);
    endtask

    task automatic send(input logic [W-1:0] d);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 2 * FL + 4) begin
            drive_cycle(1'b1, d, acc);
            tries++;
        end
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, logic'($urandom) ? 8'hFF : 8'h00, acc);
    endtask

    initial begin
        logic acc;
        n_checks  = 0;
        n_fail    = 0;
        exp_ready = 1'b1;
        rst_n     = 1'b0;
        ivalid    = 1'b0;
        idata     = '0;
        #12;
        check("rst_oq",    32'({q_m, q_l}),     32'd0);
        check("rst_busy",  32'({bsy_m, bsy_l}), 32'd0);
        check("rst_ready", 32'({rdy_m, rdy_l}), 32'd3);
        @(negedge clk);
        #2 rst_n = 1'b1;

        send(8'hA5);
        idle(FL + 2);
        send(8'h01);
        idle(FL + 2);
        send(8'hA5);
        send(8'h3C);
        idle(FL + 2);
        send(8'h07);
        idle(FL + 2);

        // Abort a frame mid-way; outputs must drop without an iclk edge.
        send(8'hFF);
        idle(4);
        #2 rst_n = 1'b0;
        #1;
        check("abort_oq",    32'({q_m, q_l}),     32'd0);
        check("abort_busy",  32'({bsy_m, bsy_l}), 32'd0);
        check("abort_frame", 32'({frm_m, frm_l}), 32'd0);
        check("abort_ready", 32'({rdy_m, rdy_l}), 32'd3);
        sb.delete();
        exp_ready = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(8'h81);
        idle(FL + 2);

        // Random traffic: idata keeps changing while ivalid waits on oready.
        for (int i = 0; i < 400; i++)
            drive_cycle(logic'($urandom_range(0, 3) != 0), W'($urandom), acc);

        ivalid = 1'b0;
        for (int i = 0; i < 2 * FL && sb.size() > 0; i++) drive_cycle(1'b0, '0, acc);
        idle(2);
        check("drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
